mem_stage_mc: RTL
=================

Name: mem_stage_mc

Overview:
- Parametrised multi-cycle data-memory stage of the pipelined MIPS CPU; successor to the single-cycle MEM stage.
- Accepts one load/store request per handshake and models WAIT_STATES cycles of memory latency, stalling the pipeline through req_ready.
- Supports byte/half/word little-endian access with sign or zero extension.
- Returns a registered MEM/WB result with a one-cycle resp_valid pulse.

Parameters:
- DEPTH_WORDS, 1024: number of 32-bit words in the data array; power of two, minimum 4.
- WAIT_STATES, 1: extra cycles between request accept and array access; range 0..7.
- IDX_W, $clog2(DEPTH_WORDS): word-index width; derived, not overridden.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- CLR_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present this cycle.
- req_ready  out  1  stage can accept a request; the pipeline stalls while this is low.
- R1_in  in  32  ALU result or byte address.
- data_in  in  32  store data from rt.
- MemWrite  in  1  1 = store, 0 = load or pass-through.
- MemtoReg  in  1  1 = R1 returns load data, 0 = R1 returns the latched R1_in.
- UnsignedExt_Mem  in  1  1 = zero-extend sub-word loads, 0 = sign-extend.
- Byte  in  1  byte access.
- Half  in  1  halfword access.
- resp_valid  out  1  one-cycle pulse: R1 and ZDX_ID_MEM are valid.
- R1  out  32  write-back value.
- ZDX_ID_MEM  out  32  extended load data, used for ID-stage forwarding.
- misalign  out  1  misaligned-access flag, qualified by resp_valid.

Behaviour:
- Reset (CLR_n low, asynchronous):
  - Outputs: state=IDLE, req_ready=1, resp_valid=0, R1=0, ZDX_ID_MEM=0, misalign=0, wait counter=0.
  - The memory array is not reset.
- Reset mid-operation: any pending access is abandoned; a pending store does not write.
- States: IDLE, WAIT, RESP.
- req_ready=1 in IDLE and RESP; req_ready=0 in WAIT.
- Accept condition: req_valid && req_ready. On accept, latch R1_in, data_in and all five control bits.
- Transitions on accept:
  - WAIT_STATES>0: go to WAIT with counter=WAIT_STATES-1.
  - WAIT_STATES=0: perform the access at the accept edge and go to RESP.
- WAIT: the counter decrements each cycle. When it reaches 0, perform the access on that edge and go to RESP.
- RESP (one cycle): resp_valid=1.
  - New request accepted: handled exactly as from IDLE (back-to-back, no bubble).
  - Otherwise: go to IDLE, and resp_valid falls.
- Latency: accept at edge N gives resp_valid high during the cycle after edge N+WAIT_STATES.
  - Throughput: one request per WAIT_STATES+1 cycles.
- Addressing:
  - Word index = addr[IDX_W+1:2]; higher address bits are ignored, so addresses wrap modulo 4*DEPTH_WORDS bytes.
  - Lane = addr[1:0].
- Size priority: Byte over Half over word. Byte=Half=1 is treated as a byte access.
- Store, Byte: write only lane addr[1:0] with data_in[7:0].
- Store, Half: write lanes {addr[1],0} and {addr[1],1} with data_in[15:0], little-endian.
- Store, word: write all 4 lanes with data_in.
- Store result: ZDX_ID_MEM=0; R1 = latched R1_in regardless of MemtoReg.
- Load: read the indexed word, select the lane, extend to 32 bits per UnsignedExt_Mem; the word is passed unchanged.
  - ZDX_ID_MEM = extended value.
  - R1 = MemtoReg ? extended value : latched R1_in.
- Read-after-write: a load accepted after a store to the same word has been accepted returns the newly written data.
- R1, ZDX_ID_MEM and misalign hold their values after resp_valid falls, until the next response.

Optional Feature:
- Macro: MEM_MISALIGN_CHECK_EN.
- Defined: a halfword access with addr[0]=1, or a word access with addr[1:0]!=0, is flagged.
  - misalign=1 with resp_valid.
  - No array write.
  - ZDX_ID_MEM=0.
  - R1 = latched R1_in.
  - Timing is unchanged.
- Not defined:
  - misalign is tied to 0.
  - Halfword accesses ignore addr[0]; word accesses ignore addr[1:0] (alignment rounds down).

Test Plan:
- Reset, then WAIT_STATES=1: store word 0xDEADBEEF to 0x10, then load word from 0x10 with MemtoReg=1. Required: resp_valid 2 cycles after each accept, req_ready low for exactly 1 cycle per request, R1=0xDEADBEEF.
- Store byte 0x80 to 0x13 over a zero word, then load byte from 0x13. Required: UnsignedExt_Mem=0 gives ZDX_ID_MEM=0xFFFFFF80; UnsignedExt_Mem=1 gives 0x00000080; the load word from 0x10 returns 0x80000000.
- Store half 0x1234 to 0x22, then load half unsigned from 0x22. Required: 0x00001234; the load word from 0x20 returns 0x12340000.
- WAIT_STATES=0, req_valid held high for 4 requests. Required: req_ready constantly 1, resp_valid high 4 consecutive cycles, no bubble.
- Word store to 0x08 with CLR_n pulsed low during WAIT (WAIT_STATES=3). Required: all outputs 0 immediately, req_ready=1, and a subsequent load from 0x08 shows the old contents.
- With MEM_MISALIGN_CHECK_EN defined: store word to 0x05. Required: misalign=1 with resp_valid and memory unchanged. Without the macro: the same store writes word index 1.

Source files
------------

// File: rtl/mem_stage_mc.sv
// Multi-cycle data-memory stage: one load/store per handshake, WAIT_STATES cycles of latency,
// registered MEM/WB result. Optional alignment checking is enabled by MEM_MISALIGN_CHECK_EN.
module mem_stage_mc #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        CLR_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] R1_in,
    input  logic [31:0] data_in,
    input  logic        MemWrite,
    input  logic        MemtoReg,
    input  logic        UnsignedExt_Mem,
    input  logic        Byte,
    input  logic        Half,
    output logic        resp_valid,
    output logic [31:0] R1,
    output logic [31:0] ZDX_ID_MEM,
    output logic        misalign,
    output logic [1:0]  dbg_state
);
    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam bit ZERO_WS = (WAIT_STATES == 0);
    localparam logic [2:0] CNT_INIT = (WAIT_STATES == 0) ? 3'd0 : 3'(WAIT_STATES - 1);

    // Encoding is visible on dbg_state: 0 = IDLE, 1 = WAIT, 2 = RESP.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        accept, do_access;

    logic [31:0] l_addr, l_data;
    logic        l_mw, l_mtr, l_uns, l_byte, l_half;

    logic [31:0] a_addr, a_data;
    logic        a_mw, a_mtr, a_uns, a_byte, a_half;

    logic [IDX_W-1:0] idx;
    logic [1:0]  lane;
    logic        mis_c, wr_en;
    logic [3:0]  be;
    logic [31:0] wdata, rword, ext;
    logic [7:0]  rbyte;
    logic [15:0] rhalf;
    logic        unused_addr_bits;

    logic [31:0] mem [DEPTH_WORDS];

    // Handshake: a request transfers on any rising edge where req_valid && req_ready;
    // req_valid may be held high, and the request fields must be stable while it waits.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        do_access = 1'b0;
        req_ready = (state_q != S_WAIT);
        accept    = req_valid && req_ready;
        case (state_q)
            S_IDLE, S_RESP: begin
                if (accept) begin
                    if (ZERO_WS) begin
                        do_access = 1'b1;
                        state_d   = S_RESP;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                if (cnt_q == 3'd0) begin
                    do_access = 1'b1;
                    state_d   = S_RESP;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge CLR_n) begin
        if (!CLR_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 3'd0;
            l_addr  <= 32'd0;
            l_data  <= 32'd0;
            l_mw    <= 1'b0;
            l_mtr   <= 1'b0;
            l_uns   <= 1'b0;
            l_byte  <= 1'b0;
            l_half  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                l_addr <= R1_in;
                l_data <= data_in;
                l_mw   <= MemWrite;
                l_mtr  <= MemtoReg;
                l_uns  <= UnsignedExt_Mem;
                l_byte <= Byte;
                l_half <= Half;
            end
        end
    end

    // With no wait states the access happens on the accept edge, so use the live request.
    assign a_addr = ZERO_WS ? R1_in           : l_addr;
    assign a_data = ZERO_WS ? data_in         : l_data;
    assign a_mw   = ZERO_WS ? MemWrite        : l_mw;
    assign a_mtr  = ZERO_WS ? MemtoReg        : l_mtr;
    assign a_uns  = ZERO_WS ? UnsignedExt_Mem : l_uns;
    assign a_byte = ZERO_WS ? Byte            : l_byte;
    assign a_half = ZERO_WS ? Half            : l_half;

    assign idx  = a_addr[IDX_W+1:2];
    assign lane = a_addr[1:0];
    assign unused_addr_bits = ^a_addr[31:IDX_W+2];

`ifdef MEM_MISALIGN_CHECK_EN
    assign mis_c = !a_byte && ((a_half && a_addr[0]) || (!a_half && (a_addr[1:0] != 2'b00)));
`else
    assign mis_c = 1'b0;
`endif

    // Reset gates the write so an accept seen while CLR_n is low cannot store.
    assign wr_en = do_access && a_mw && !mis_c && CLR_n;

    always_comb begin
        be    = 4'b1111;
        wdata = a_data;
        if (a_byte) begin
            be    = 4'b0001 << lane;
            wdata = {4{a_data[7:0]}};
        end else if (a_half) begin
            be    = a_addr[1] ? 4'b1100 : 4'b0011;
            wdata = {2{a_data[15:0]}};
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    always_comb begin
        rword = mem[idx];
        rbyte = rword[{lane, 3'b000} +: 8];
        rhalf = rword[{a_addr[1], 4'b0000} +: 16];
        if (a_byte)      ext = a_uns ? {24'd0, rbyte} : {{24{rbyte[7]}}, rbyte};
        else if (a_half) ext = a_uns ? {16'd0, rhalf} : {{16{rhalf[15]}}, rhalf};
        else             ext = rword;
    end

    always_ff @(posedge clk or negedge CLR_n) begin
        if (!CLR_n) begin
            R1         <= 32'd0;
            ZDX_ID_MEM <= 32'd0;
        end else if (do_access) begin
            if (a_mw || mis_c) begin
                R1         <= a_addr;
                ZDX_ID_MEM <= 32'd0;
            end else begin
                R1         <= a_mtr ? ext : a_addr;
                ZDX_ID_MEM <= ext;
            end
        end
    end

`ifdef MEM_MISALIGN_CHECK_EN
    logic mis_q;
    always_ff @(posedge clk or negedge CLR_n) begin
        if (!CLR_n)         mis_q <= 1'b0;
        else if (do_access) mis_q <= mis_c;
    end
    assign misalign = mis_q;
`else
    assign misalign = 1'b0;
`endif

    assign resp_valid = (state_q == S_RESP);
    assign dbg_state  = state_q;

endmodule
